tea_io_uart: RTL and testbench

Memory-mapped 8N1 UART peripheral on the tea_cpu I/O bus (io_addr/io_rd/io_wr/io_rddata/io_wrdata). It occupies four consecutive I/O addresses and provides a 4-deep transmit FIFO, a single-byte receive holding register with error flags, and a programmable baud divisor. It is the first I/O slave attached downstream of the CPU core. Its io_rddata is zero when not selected, so several slaves can be OR-combined onto the CPU read bus.

---
 rtl/tea_io_uart.sv | 160 ++++++++++++++++
 tb/tb_tea_io_uart.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tea_io_uart.sv
// tea_io_uart: memory-mapped 8N1 UART with a 4-deep TX FIFO, one-byte RX holding register and programmable baud divisor.
module tea_io_uart #(
    parameter logic [4:0]  BASE_ADDR   = 5'h10,
    parameter logic [15:0] DEFAULT_DIV = 16'd867,
    parameter int          TX_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] io_addr,
    input  logic       io_rd,
    input  logic       io_wr,
    input  logic [7:0] io_wrdata,
    output logic [7:0] io_rddata,
    input  logic       rxd,
    output logic       txd,
    output logic       irq
);
    localparam int AW = $clog2(TX_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(TX_DEPTH);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    logic          hit, rd_data, wr_data, wr_stat;
    logic [1:0]    off;
    logic [15:0]   div_q, eff_div, rx_half;
    logic [7:0]    fifo [TX_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          tx_full, tx_empty, push, pop, tx_last;
    logic          tx_busy;
    logic [7:0]    tx_data;
    logic [9:0]    tx_frame;
    logic [3:0]    tx_bit;
    logic [15:0]   tx_cnt;
    logic          rx_s1, rx_s2, rx_prev;
    rx_state_t     rx_state, rx_state_n;
    logic [15:0]   rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_sh, rx_sh_n, rx_data;
    logic          deliver, ferr_set;
    logic          rx_valid, rx_overrun, frame_err, tx_drop;
    logic [7:0]    status;
    assign hit      = io_addr[4:2] == BASE_ADDR[4:2];
    assign off      = io_addr[1:0];
    assign rd_data  = io_rd && hit && off == 2'd0;
    assign wr_data  = io_wr && hit && off == 2'd0;
    assign wr_stat  = io_wr && hit && off == 2'd1;
    assign eff_div  = div_q < 16'd3 ? 16'd3 : div_q;
    assign rx_half  = 16'((17'(eff_div) + 17'd1) >> 1) - 16'd1;
    assign tx_full  = count == DEPTH_C;
    assign tx_empty = count == '0 && !tx_busy;
    assign push     = wr_data && !tx_full;
    // The last cycle of a stop bit hands straight over to the next queued byte.
    assign tx_last  = tx_busy && tx_cnt == 16'd0 && tx_bit == 4'd9;
    assign pop      = count != '0 && (!tx_busy || tx_last);
    assign tx_frame = {1'b1, tx_data, 1'b0};
    assign irq      = rx_valid;
    assign status   = {1'b0, tx_drop, frame_err, tx_busy, tx_empty, tx_full, rx_overrun, rx_valid};
    assign io_rddata = !(io_rd && hit) ? 8'h00 :
                       off == 2'd0 ? rx_data :
                       off == 2'd1 ? status :
                       off == 2'd2 ? div_q[7:0] : div_q[15:8];
    always_ff @(posedge clk) begin
        if (push) fifo[wptr] <= io_wrdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= DEFAULT_DIV;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            tx_busy <= 1'b0;
            tx_data <= 8'h00;
            tx_bit  <= 4'd0;
            tx_cnt  <= 16'd0;
            txd     <= 1'b1;
            tx_drop <= 1'b0;
        end else begin
            if (io_wr && hit && off == 2'd2) div_q[7:0] <= io_wrdata;
            if (io_wr && hit && off == 2'd3) div_q[15:8] <= io_wrdata;
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            tx_drop <= (wr_data && tx_full) | (tx_drop & ~(wr_stat & io_wrdata[6]));
            if (pop) begin
                tx_busy <= 1'b1;
                tx_data <= fifo[rptr];
                tx_bit  <= 4'd0;
                tx_cnt  <= eff_div;
            end else if (tx_last) begin
                tx_busy <= 1'b0;
            end else if (tx_busy) begin
                tx_cnt <= tx_cnt == 16'd0 ? eff_div : tx_cnt - 16'd1;
                tx_bit <= tx_cnt == 16'd0 ? tx_bit + 4'd1 : tx_bit;
            end
            txd <= tx_busy ? tx_frame[tx_bit] : 1'b1;
        end
    end
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        deliver    = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state)
            RX_IDLE: if (rx_prev && !rx_s2) begin
                rx_state_n = RX_START;
                rx_cnt_n   = rx_half;
            end
            RX_START: if (rx_cnt != 16'd0) rx_cnt_n = rx_cnt - 16'd1;
                else if (rx_s2) rx_state_n = RX_IDLE;
                else begin
                    rx_state_n = RX_DATA;
                    rx_cnt_n   = eff_div;
                    rx_bit_n   = 3'd0;
                end
            RX_DATA: if (rx_cnt != 16'd0) rx_cnt_n = rx_cnt - 16'd1;
                else begin
                    rx_sh_n    = {rx_s2, rx_sh[7:1]};
                    rx_cnt_n   = eff_div;
                    rx_bit_n   = rx_bit + 3'd1;
                    rx_state_n = rx_bit == 3'd7 ? RX_STOP : RX_DATA;
                end
            RX_STOP: if (rx_cnt != 16'd0) rx_cnt_n = rx_cnt - 16'd1;
                else begin
                    rx_state_n = RX_IDLE;
                    deliver    = rx_s2;
                    ferr_set   = !rx_s2;
                end
            default: rx_state_n = RX_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= 16'd0;
            rx_bit     <= 3'd0;
            rx_sh      <= 8'h00;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rxd;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_bit     <= rx_bit_n;
            rx_sh      <= rx_sh_n;
            // A delivery coinciding with a DATA read replaces the byte instead of overrunning.
            if (deliver && (!rx_valid || rd_data)) rx_data <= rx_sh;
            rx_valid   <= deliver ? 1'b1 : rd_data ? 1'b0 : rx_valid;
            rx_overrun <= (deliver && rx_valid && !rd_data) | (rx_overrun & ~(wr_stat & io_wrdata[1]));
            frame_err  <= ferr_set | (frame_err & ~(wr_stat & io_wrdata[5]));
        end
    end
endmodule

// File: tb/tb_tea_io_uart.sv
// tb_tea_io_uart: directed bench for tea_io_uart at DIV=3 covering reset, TX timing, FIFO overflow, RX, errors and mid-frame reset.
module tb_tea_io_uart;
    logic       clk = 1'b0, rst_n = 1'b0, io_rd = 1'b0, io_wr = 1'b0, rxd = 1'b1;
    logic [4:0] io_addr = 5'h00;
    logic [7:0] io_wrdata = 8'h00;
    logic [7:0] io_rddata;
    logic       txd, irq;
    int         n_cmp = 0, n_err = 0;
    logic [7:0] ob [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    logic [9:0] f;
    logic [7:0] d;
    tea_io_uart dut (
        .clk(clk), .rst_n(rst_n), .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr),
        .io_wrdata(io_wrdata), .io_rddata(io_rddata), .rxd(rxd), .txd(txd), .irq(irq)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic rd(input logic [1:0] o, output logic [7:0] v);
        io_addr = 5'h10 + {3'b000, o};
        io_rd = 1'b1;
        #1 v = io_rddata;
        tick();
        io_rd = 1'b0;
    endtask
    task automatic chk_rd(input string tag, input logic [1:0] o, input logic [7:0] exp);
        logic [7:0] v;
        rd(o, v);
        chk(tag, v, exp);
    endtask
    task automatic wr(input logic [1:0] o, input logic [7:0] v);
        io_addr = 5'h10 + {3'b000, o};
        io_wrdata = v;
        io_wr = 1'b1;
        tick();
        io_wr = 1'b0;
    endtask
    // Call right after wr() to DATA with an idle transmitter; checks latency, all 40 bit-cycles and STATUS.
    task automatic tx_check(input string tag, input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        chk({tag, "_lat0"}, {7'b0, txd}, 8'h01);
        tick();
        chk({tag, "_lat1"}, {7'b0, txd}, 8'h01);
        tick();
        io_addr = 5'h11;
        io_rd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            chk({tag, "_bit"}, {7'b0, txd}, {7'b0, fr[i/4]});
            if (i == 20) chk({tag, "_busy"}, io_rddata, 8'h10);
            tick();
        end
        chk({tag, "_idle"}, {7'b0, txd}, 8'h01);
        chk({tag, "_empty"}, io_rddata, 8'h08);
        io_rd = 1'b0;
    endtask
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            tick(4);
        end
        rxd = 1'b1;
    endtask
    initial begin
        tick(3);
        chk("rst_txd", {7'b0, txd}, 8'h01);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        chk("rst_rddata", io_rddata, 8'h00);
        rst_n = 1'b1;
        tick(2);
        chk_rd("rst_status", 2'd1, 8'h08);
        chk_rd("rst_baud_lo", 2'd2, 8'h63);
        chk_rd("rst_baud_hi", 2'd3, 8'h03);
        chk("rst_txd_idle", {7'b0, txd}, 8'h01);
        wr(2'd2, 8'h03);
        wr(2'd3, 8'h00);
        chk_rd("baud_lo", 2'd2, 8'h03);
        chk_rd("baud_hi", 2'd3, 8'h00);
        io_addr = 5'h0C;
        io_rd = 1'b1;
        #1 chk("miss_rd", io_rddata, 8'h00);
        io_rd = 1'b0;
        io_addr = 5'h14;
        io_wrdata = 8'h99;
        io_wr = 1'b1;
        tick();
        io_wr = 1'b0;
        tick(3);
        chk("miss_wr_txd", {7'b0, txd}, 8'h01);
        chk_rd("miss_wr_status", 2'd1, 8'h08);
        wr(2'd0, 8'hA5);
        tx_check("tx_a5", 8'hA5);
        for (int k = 0; k < 6; k++) begin
            io_addr = 5'h10;
            io_wrdata = k < 5 ? ob[k] : 8'h77;
            io_wr = 1'b1;
            tick();
        end
        io_wr = 1'b0;
        chk_rd("ovf_status", 2'd1, 8'h54);
        wr(2'd1, 8'h40);
        chk_rd("ovf_clr", 2'd1, 8'h14);
        for (int i = 6; i < 200; i++) begin
            f = {1'b1, ob[i/40], 1'b0};
            chk("ovf_txd", {7'b0, txd}, {7'b0, f[(i%40)/4]});
            tick();
        end
        chk("ovf_idle", {7'b0, txd}, 8'h01);
        chk_rd("ovf_empty", 2'd1, 8'h08);
        send_rx(8'h3C, 1'b1);
        tick(3);
        chk("rx_irq", {7'b0, irq}, 8'h01);
        chk_rd("rx_status", 2'd1, 8'h09);
        chk_rd("rx_data", 2'd0, 8'h3C);
        chk("rx_irq_clr", {7'b0, irq}, 8'h00);
        chk_rd("rx_status_clr", 2'd1, 8'h08);
        send_rx(8'h3C, 1'b1);
        send_rx(8'h55, 1'b1);
        tick(3);
        chk_rd("ovr_status", 2'd1, 8'h0B);
        chk_rd("ovr_data", 2'd0, 8'h3C);
        chk_rd("ovr_after_rd", 2'd1, 8'h0A);
        wr(2'd1, 8'h02);
        chk_rd("ovr_clr", 2'd1, 8'h08);
        send_rx(8'h81, 1'b1);
        send_rx(8'h7E, 1'b0);
        tick(3);
        chk_rd("ferr_status", 2'd1, 8'h29);
        chk_rd("ferr_data", 2'd0, 8'h81);
        wr(2'd1, 8'h20);
        chk_rd("ferr_clr", 2'd1, 8'h08);
        rxd = 1'b0;
        tick();
        rxd = 1'b1;
        tick(50);
        chk("glitch_irq", {7'b0, irq}, 8'h00);
        chk_rd("glitch_status", 2'd1, 8'h08);
        wr(2'd0, 8'h5A);
        wr(2'd0, 8'h11);
        tick(14);
        chk("pre_rst_txd", {7'b0, txd}, 8'h00);
        rst_n = 1'b0;
        #1 chk("mid_rst_txd", {7'b0, txd}, 8'h01);
        io_addr = 5'h11;
        io_rd = 1'b1;
        #1 chk("mid_rst_status", io_rddata, 8'h08);
        io_rd = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk_rd("post_rst_baud", 2'd2, 8'h63);
        chk_rd("post_rst_status", 2'd1, 8'h08);
        wr(2'd2, 8'h03);
        wr(2'd3, 8'h00);
        chk("post_rst_txd", {7'b0, txd}, 8'h01);
        wr(2'd0, 8'hC6);
        tx_check("tx_c6", 8'hC6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
